// File: rtl/fsm_self_test_checker_if.sv
// Self-test scenario bus: one valid strobe plus the 8-bit word {count[6:0], test_bit}.
// The self-test FSM drives it through the master modport, and the checker receives it
// through the slave modport.
interface fsm_self_test_checker_if;
  logic       sample_valid;
  logic [7:0] scenario_word;

  modport master (
    output sample_valid,
    output scenario_word
  );

  modport slave (
    input sample_valid,
    input scenario_word
  );
endinterface

// File: rtl/fsm_self_test_checker.sv
// Receive-side checker for the self-test scenario bus.
// After arm, it waits for the test phase (test_bit=1). It then checks that the 7-bit count
// advances by one per valid sample, modulo 128.
// It reports lock, pass/fail with a reason, and saturating error and good-sample counts.
// Optional feature: define FSM_SELF_TEST_CHK_LOG_EN to capture the expected and actual
// counts of the first mismatch in a run.
// Without that macro, first_err_exp and first_err_act are tied to 0.
module fsm_self_test_checker #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned PASS_COUNT = 1024,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          abort,
  fsm_self_test_checker_if.slave        bus,
  output logic                          locked,
  output logic                          pass,
  output logic                          fail,
  output logic [1:0]                    fail_reason,
  output logic [7:0]                    err_count,
  output logic [31:0]                   good_count,
  output logic [2:0]                    chk_state,
  output logic [6:0]                    first_err_exp,
  output logic [6:0]                    first_err_act
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] ReasonNone    = 2'd0;
  localparam logic [1:0] ReasonTimeout = 2'd1;
  localparam logic [1:0] ReasonErrLim  = 2'd2;
  localparam logic [1:0] ReasonDropped = 2'd3;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitStart = 3'd1,
    StTrack     = 3'd2,
    StPass      = 3'd3,
    StFail      = 3'd4
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timeout_q;
  logic [6:0]    expected_q;
  logic [RW-1:0] run_q;

  logic [6:0]    word_count;
  logic          word_test;
  logic [7:0]    err_inc;
  logic [31:0]   good_inc;
  logic [RW-1:0] run_inc;

  assign word_count = bus.scenario_word[7:1];
  assign word_test  = bus.scenario_word[0];

  // Saturating increments; run only needs to count as far as the lock threshold.
  assign err_inc  = (err_count == 8'hff) ? err_count : err_count + 8'd1;
  assign good_inc = (&good_count) ? good_count : good_count + 32'd1;
  assign run_inc  = (run_q == RW'(LOCK_COUNT)) ? run_q : run_q + RW'(1);

  assign chk_state = state_q;

`ifdef FSM_SELF_TEST_CHK_LOG_EN
  logic first_err_seen_q;
`else
  assign first_err_exp = 7'd0;
  assign first_err_act = 7'd0;
`endif

  // Checker FSM: control priority is reset > abort > arm > sample processing.
  always_ff @(posedge clock) begin
    if (reset || abort || arm) begin
      state_q     <= (reset || abort) ? StIdle : StWaitStart;
      timeout_q   <= '0;
      expected_q  <= '0;
      run_q       <= '0;
      locked      <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_reason <= ReasonNone;
      err_count   <= '0;
      good_count  <= '0;
`ifdef FSM_SELF_TEST_CHK_LOG_EN
      first_err_seen_q <= 1'b0;
      first_err_exp    <= '0;
      first_err_act    <= '0;
`endif
    end else begin
      unique case (state_q)
        StWaitStart: begin
          if (bus.sample_valid && word_test) begin
            // The first test-phase sample seeds the expected count and counts as good.
            expected_q <= word_count + 7'd1;
            good_count <= 32'd1;
            run_q      <= RW'(1);
            locked     <= (LOCK_COUNT <= 1);
            state_q    <= StTrack;
          end else if (timeout_q == TW'(TIMEOUT - 1)) begin
            state_q     <= StFail;
            fail        <= 1'b1;
            fail_reason <= ReasonTimeout;
            locked      <= 1'b0;
          end else begin
            timeout_q <= timeout_q + TW'(1);
          end
        end
        StTrack: begin
          if (bus.sample_valid) begin
            if (!word_test) begin
              state_q     <= StFail;
              fail        <= 1'b1;
              fail_reason <= ReasonDropped;
              locked      <= 1'b0;
            end else if (word_count == expected_q) begin
              good_count <= good_inc;
              run_q      <= run_inc;
              expected_q <= expected_q + 7'd1;
              if (run_inc == RW'(LOCK_COUNT)) locked <= 1'b1;
              if (good_inc >= PASS_COUNT) begin
                state_q <= StPass;
                pass    <= 1'b1;
                locked  <= 1'b0;
              end
            end else begin
              // Mismatch: resync on the received count. good_count is unchanged here, so
              // the error limit can never coincide with a pass on the same sample.
              err_count  <= err_inc;
              run_q      <= '0;
              locked     <= 1'b0;
              expected_q <= word_count + 7'd1;
`ifdef FSM_SELF_TEST_CHK_LOG_EN
              if (!first_err_seen_q) begin
                first_err_seen_q <= 1'b1;
                first_err_exp    <= expected_q;
                first_err_act    <= word_count;
              end
`endif
              if ({24'd0, err_inc} >= ERR_LIMIT) begin
                state_q     <= StFail;
                fail        <= 1'b1;
                fail_reason <= ReasonErrLim;
              end
            end
          end
        end
        // IDLE, PASS and FAIL hold everything until arm or abort.
        default: ;
      endcase
    end
  end

endmodule
